// File: rtl/uram_arb_pkg.sv
// Shared types and constants for the URAM port arbiter.
package uram_arb_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned STAT_W  = 32;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_e;

   typedef logic [0:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/uram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner.
module rr_arb2
   import uram_arb_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant_c
);

   req_id_t last_q;

   // On contention the requester that did not win last time is granted
   always_comb begin
      grant_c = '0;
      if (req == 2'b11) begin
         grant_c = (last_q == 1'b1) ? 2'b01 : 2'b10;
      end else begin
         grant_c = req;
      end
   end

   // Pointer follows every grant in this class
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= '0;
      end else if (|req) begin
         last_q <= req_id_t'(grant_c[1]);
      end
   end

endmodule

// File: rtl/uram_port_arbiter.sv
// Shares one simple-dual-port URAM bank between two requesters.
// Reads and writes are arbitrated independently; the bank is zero-filled
// after reset. Define URAM_ARB_STATS_EN to add per-requester stall counters.
module uram_port_arbiter
   import uram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDRESS_WIDTH  = 12,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic                     req0_wen,
   input  logic [ADDRESS_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0]    req0_wdata,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic                     req1_wen,
   input  logic [ADDRESS_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0]    req1_wdata,
   output logic                     rsp0_valid,
   output logic [DATA_WIDTH-1:0]    rsp0_data,
   output logic                     rsp1_valid,
   output logic [DATA_WIDTH-1:0]    rsp1_data,
   output logic [ADDRESS_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0]    mem_dout,
   output logic                     mem_wen,
   output logic [ADDRESS_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0]    mem_din,
   output logic                     init_done
`ifdef URAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]        stall0_count,
   output logic [STAT_W-1:0]        stall1_count
`endif
);

   localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

   arb_state_e         state_q;
   logic [CNT_W-1:0]   clr_cnt_q;
   logic [CNT_W-1:0]   clr_cnt_next_c;
   rd_tag_t            tag_q;
   logic               active_c;
   logic [NUM_REQ-1:0] rd_req_c;
   logic [NUM_REQ-1:0] wr_req_c;
   logic [NUM_REQ-1:0] rd_gnt_c;
   logic [NUM_REQ-1:0] wr_gnt_c;

   // Traffic is only considered in RUN and never while reset is held
   assign active_c       = (state_q == ST_RUN) && !reset;
   assign clr_cnt_next_c = clr_cnt_q + CNT_W'(1);

   assign rd_req_c = {active_c & req1_valid & ~req1_wen, active_c & req0_valid & ~req0_wen};
   assign wr_req_c = {active_c & req1_valid &  req1_wen, active_c & req0_valid &  req0_wen};

   rr_arb2 u_rd_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (rd_req_c),
      .grant_c (rd_gnt_c)
   );

   rr_arb2 u_wr_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (wr_req_c),
      .grant_c (wr_gnt_c)
   );

   assign req0_ready = rd_gnt_c[0] | wr_gnt_c[0];
   assign req1_ready = rd_gnt_c[1] | wr_gnt_c[1];

   // Memory ports follow the grants; the clear sweep owns the write port
   always_comb begin
      mem_raddr = '0;
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_din   = '0;
      if (rd_gnt_c[1]) begin
         mem_raddr = req1_addr;
      end else if (rd_gnt_c[0]) begin
         mem_raddr = req0_addr;
      end
      if ((state_q == ST_CLEAR) && !reset) begin
         mem_wen   = 1'b1;
         mem_waddr = clr_cnt_q[ADDRESS_WIDTH-1:0];
      end else if (wr_gnt_c[1]) begin
         mem_wen   = 1'b1;
         mem_waddr = req1_addr;
         mem_din   = req1_wdata;
      end else if (wr_gnt_c[0]) begin
         mem_wen   = 1'b1;
         mem_waddr = req0_addr;
         mem_din   = req0_wdata;
      end
   end

   // Clear sweep then RUN; the extra counter bit flags the wrap past the last address
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_cnt_q <= '0;
         init_done <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_next_c;
               if (clr_cnt_next_c[ADDRESS_WIDTH]) begin
                  state_q   <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               init_done <= 1'b1;
            end
            default: begin
               state_q <= ST_CLEAR;
            end
         endcase
      end
   end

   // Read tag: who gets mem_dout on the following cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_q <= '0;
      end else begin
         tag_q.valid <= |rd_gnt_c;
         tag_q.id    <= req_id_t'(rd_gnt_c[1]);
      end
   end

   assign rsp0_valid = tag_q.valid && (tag_q.id == 1'b0);
   assign rsp1_valid = tag_q.valid && (tag_q.id == 1'b1);
   assign rsp0_data  = mem_dout;
   assign rsp1_data  = mem_dout;

`ifdef URAM_ARB_STATS_EN
   // Saturating count of RUN cycles where a request waited
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall0_count <= '0;
         stall1_count <= '0;
      end else if (state_q == ST_RUN) begin
         if (req0_valid && !req0_ready && !(&stall0_count)) begin
            stall0_count <= stall0_count + STAT_W'(1);
         end
         if (req1_valid && !req1_ready && !(&stall1_count)) begin
            stall1_count <= stall1_count + STAT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Scoreboard bench for uram_port_arbiter with a read_first memory model.
module tb_uram_port_arbiter;

   localparam int unsigned DW    = 64;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req0_wen;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, req1_wen;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic [DW-1:0] mem_dout, mem_din;
   logic          mem_wen;
   logic          init_done;
`ifdef URAM_ARB_STATS_EN
   logic [31:0]   stall0_count, stall1_count;
`endif

   uram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_wen   (req0_wen),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_wen   (req1_wen),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .mem_raddr  (mem_raddr),
      .mem_dout   (mem_dout),
      .mem_wen    (mem_wen),
      .mem_waddr  (mem_waddr),
      .mem_din    (mem_din),
      .init_done  (init_done)
`ifdef URAM_ARB_STATS_EN
      ,
      .stall0_count (stall0_count),
      .stall1_count (stall1_count)
`endif
   );

   always #5 clock = ~clock;

   int unsigned cyc_cnt = 0;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   // Memory model: read_first, 1-cycle read latency, plus a bench backdoor port
   logic [DW-1:0] mem [DEPTH];
   logic          bd_en = 1'b0;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;
   always @(posedge clock) begin
      mem_dout <= mem[mem_raddr];
      if (bd_en) mem[bd_addr] <= bd_data;
      if (mem_wen) mem[mem_waddr] <= mem_din;
   end

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int unsigned   cyc;
   } exp_t;
   exp_t q[$];

   int total = 0;
   int bad   = 0;

   logic          s_r0, s_r1, s_wen;
   logic [AW-1:0] s_waddr, s_raddr;
   logic [DW-1:0] s_din;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_addr = a;
      bd_data = d;
      bd_en   = 1'b1;
      @(posedge clock);
      #1 bd_en = 1'b0;
   endtask

   // One cycle: sample at negedge, log accepted reads, advance to posedge+1
   task automatic step(input logic [DW-1:0] e0, input logic [DW-1:0] e1, input bit push_en);
      exp_t e;
      @(negedge clock);
      s_r0 = req0_ready;  s_r1 = req1_ready;
      s_wen = mem_wen;    s_waddr = mem_waddr;
      s_din = mem_din;    s_raddr = mem_raddr;
      if (push_en && req0_valid && req0_ready && !req0_wen) begin
         e = '{1'b0, e0, cyc_cnt};
         q.push_back(e);
      end
      if (push_en && req1_valid && req1_ready && !req1_wen) begin
         e = '{1'b1, e1, cyc_cnt};
         q.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_rsp(input logic id, input logic [DW-1:0] d);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL rsp_unexpected: rsp%0d_valid=1 with nothing outstanding (required 0)", id);
      end else begin
         e = q.pop_front();
         chk("rsp_id", DW'(id), DW'(e.id));
         chk("rsp_data", d, e.data);
         chk("rsp_latency", DW'(cyc_cnt), DW'(e.cyc + 1));
      end
   endtask

   // Monitor: every response pulse is matched against the scoreboard
   always @(negedge clock) begin
      if (rsp0_valid) check_rsp(1'b0, rsp0_data);
      if (rsp1_valid) check_rsp(1'b1, rsp1_data);
   end

   initial begin
      reset = 1'b1;
      req0_valid = 0; req0_wen = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_wen = 0; req1_addr = '0; req1_wdata = '0;
      poke(4'd15, 64'hFFFF);
      poke(4'd0,  64'hFFFF);

      // Reset values, with requests pending
      req0_valid = 1; req1_valid = 1; req1_wen = 1;
      @(negedge clock);
      chk("rst_init_done", DW'(init_done), 0);
      chk("rst_ready", DW'({req1_ready, req0_ready}), 0);
      chk("rst_rsp_valid", DW'({rsp1_valid, rsp0_valid}), 0);
      chk("rst_mem_wen", DW'(mem_wen), 0);
      chk("rst_mem_addr", DW'({mem_raddr, mem_waddr}), 0);
      chk("rst_mem_din", mem_din, 0);
`ifdef URAM_ARB_STATS_EN
      chk("rst_stall0", DW'(stall0_count), 0);
      chk("rst_stall1", DW'(stall1_count), 0);
`endif
      @(posedge clock);
      #1 reset = 1'b0;

      // Clear sweep: 16 zero writes, requests held off
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         chk("clr_wen", DW'(mem_wen), 1);
         chk("clr_waddr", DW'(mem_waddr), DW'(i));
         chk("clr_din", mem_din, 0);
         chk("clr_ready", DW'({req1_ready, req0_ready}), 0);
         chk("clr_init_done", DW'(init_done), 0);
         if (i == 15) begin
            req0_valid = 0; req1_valid = 0; req1_wen = 0;
         end
      end
      @(negedge clock);
      chk("clr_done", DW'(init_done), 1);
      chk("run_idle_wen", DW'(mem_wen), 0);
      chk("clr_mem15", mem[15], 0);
      chk("clr_mem0", mem[0], 0);
`ifdef URAM_ARB_STATS_EN
      chk("clr_stall0", DW'(stall0_count), 0);
      chk("clr_stall1", DW'(stall1_count), 0);
`endif
      @(posedge clock);
      #1;

      // Single read
      poke(4'd5, 64'hDEAD);
      req0_valid = 1; req0_wen = 0; req0_addr = 4'd5;
      step(64'hDEAD, '0, 1);
      chk("rd1_ready0", DW'(s_r0), 1);
      chk("rd1_ready1", DW'(s_r1), 0);
      chk("rd1_raddr", DW'(s_raddr), 5);
      req0_valid = 0;
      step('0, '0, 0);
      step('0, '0, 0);

      // Dual-read contention: req1 wins first, then alternate
      poke(4'd1, 64'hA1);
      poke(4'd2, 64'hB2);
      req0_valid = 1; req0_addr = 4'd1;
      req1_valid = 1; req1_addr = 4'd2; req1_wen = 0;
      for (int k = 0; k < 10; k++) begin
         step(64'hA1, 64'hB2, 1);
         chk("cont_ready1", DW'(s_r1), DW'(k % 2 == 0));
         chk("cont_ready0", DW'(s_r0), DW'(k % 2 == 1));
         chk("cont_raddr", DW'(s_raddr), (k % 2 == 0) ? 2 : 1);
      end
      req0_valid = 0; req1_valid = 0;
      step('0, '0, 0);
`ifdef URAM_ARB_STATS_EN
      chk("stat_stall0", DW'(stall0_count), 5);
      chk("stat_stall1", DW'(stall1_count), 5);
`endif

      // Same-address read and write in one cycle: read sees old data
      poke(4'd5, 64'h1111);
      req0_valid = 1; req0_wen = 1; req0_addr = 4'd5; req0_wdata = 64'hBEEF;
      req1_valid = 1; req1_wen = 0; req1_addr = 4'd5;
      step('0, 64'h1111, 1);
      chk("rw_ready", DW'({s_r1, s_r0}), 3);
      chk("rw_wen", DW'(s_wen), 1);
      chk("rw_waddr", DW'(s_waddr), 5);
      chk("rw_din", s_din, 64'hBEEF);
      chk("rw_raddr", DW'(s_raddr), 5);
      req0_valid = 0; req1_valid = 0;
      step('0, '0, 0);
      req0_valid = 1; req0_wen = 0; req0_addr = 4'd5;
      step(64'hBEEF, '0, 1);
      chk("rw_reread_ready", DW'(s_r0), 1);
      req0_valid = 0;
      step('0, '0, 0);

      // Write contention: write pointer last granted req0, so req1 first
      req0_valid = 1; req0_wen = 1; req0_addr = 4'd3; req0_wdata = 64'h33;
      req1_valid = 1; req1_wen = 1; req1_addr = 4'd4; req1_wdata = 64'h44;
      step('0, '0, 1);
      chk("wc_ready", DW'({s_r1, s_r0}), 2);
      chk("wc_waddr_a", DW'(s_waddr), 4);
      chk("wc_din_a", s_din, 64'h44);
      req1_valid = 0;
      step('0, '0, 1);
      chk("wc_ready_b", DW'({s_r1, s_r0}), 1);
      chk("wc_waddr_b", DW'(s_waddr), 3);
      chk("wc_din_b", s_din, 64'h33);
      req0_valid = 0; req0_wen = 0;
`ifdef URAM_ARB_STATS_EN
      step('0, '0, 0);
      chk("wc_stall0", DW'(stall0_count), 6);
      chk("wc_stall1", DW'(stall1_count), 5);
`endif

      // Back-to-back uncontended reads
      req0_valid = 1; req0_addr = 4'd3;
      step(64'h33, '0, 1);
      chk("b2b_ready_a", DW'(s_r0), 1);
      req0_addr = 4'd4;
      step(64'h44, '0, 1);
      chk("b2b_ready_b", DW'(s_r0), 1);
      req0_valid = 0;
      step('0, '0, 0);

      // Mid-read reset: tag dropped, no response; read pointer left at req1
      req1_valid = 1; req1_wen = 0; req1_addr = 4'd4;
      step('0, '0, 0);
      chk("mr_ready1", DW'(s_r1), 1);
      reset = 1'b1;
      req1_valid = 0;
      @(negedge clock);
      chk("mr_rsp_valid", DW'({rsp1_valid, rsp0_valid}), 0);
      chk("mr_init_done", DW'(init_done), 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Mid-clear reset at counter 7, sweep restarts from 0
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("mc_waddr", DW'(mem_waddr), DW'(i));
         chk("mc_wen", DW'(mem_wen), 1);
      end
      reset = 1'b1;
      #1;
      chk("mc_rst_wen", DW'(mem_wen), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         chk("mc2_waddr", DW'(mem_waddr), DW'(i));
         chk("mc2_wen", DW'(mem_wen), 1);
      end
      @(negedge clock);
      chk("mc2_done", DW'(init_done), 1);
`ifdef URAM_ARB_STATS_EN
      chk("mc2_stall0", DW'(stall0_count), 0);
`endif
      @(posedge clock);
      #1;

      // Pointer reset: req1 wins first again; memory now zero
      req0_valid = 1; req0_wen = 0; req0_addr = 4'd1;
      req1_valid = 1; req1_wen = 0; req1_addr = 4'd2;
      step('0, '0, 1);
      chk("ptr_rst_first", DW'({s_r1, s_r0}), 2);
      step('0, '0, 1);
      chk("ptr_rst_second", DW'({s_r1, s_r0}), 1);
      req0_valid = 0; req1_valid = 0;
      step('0, '0, 0);
      step('0, '0, 0);

      chk("scoreboard_empty", DW'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
